riscv_mc_sequencer: RTL and testbench
=====================================

RISCV_MC_SEQUENCER -- requirements
Module: riscv_mc_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low; ports listed below (name direction width meaning).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  7  opcode field from instruction register; stable from DECODE until the next FETCH completes.
REQ-005 funct3  in  3  funct3 field from instruction register.
REQ-006 funct7  in  7  funct7 field from instruction register.
REQ-007 zero  in  1  ALU zero flag, current cycle.
REQ-008 mem_ready  in  1  memory completes the access this cycle.
REQ-009 mem_req  out  1  memory access request.
REQ-010 mem_write  out  1  access is a store.
REQ-011 adr_src  out  1  memory address: 0 PC, 1 ALUOut.
REQ-012 ir_write  out  1  load IR and oldPC.
REQ-013 pc_write  out  1  PC load strobe.
REQ-014 reg_write  out  1  register file write strobe.
REQ-015 alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1.
REQ-016 alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-017 alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0110 SLT, 0111 MUL.
REQ-018 imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-019 result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result.
REQ-020 illegal  out  1  sticky unsupported-opcode flag.
REQ-021 state_o  out  4  current state encoding, for debug.

Function
REQ-022 SHALL be a Moore FSM; outputs decode from state only, except pc_write and ir_write, which are also gated by mem_ready/zero as stated below.
REQ-023 State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR_ADR 11, TRAP 12; codes 13-15 go to FETCH.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 FETCH: mem_req=1, adr_src=0, a=00, b=10, ADD, result=10, ir_write=pc_write=mem_ready; hold until mem_ready, then DECODE.
REQ-026 DECODE: a=01, b=01, ADD, imm_src per opcode (B 010, J 011, AUIPC 100, else 000).
REQ-026a DECODE next state: 0x03/0x23 MEMADR, 0x33 EXEC_R, 0x13 EXEC_I, 0x63 BRANCH, 0x6F JAL, 0x67 JALR_ADR, 0x17 ALUWB; any other opcode TRAP.
REQ-027 MEMADR: a=10, b=01, ADD, imm_src 000 for load or 001 for store; next MEMREAD for load, MEMWRITE for store.
REQ-028 MEMREAD: mem_req=1, adr_src=1; hold until mem_ready, then MEMWB.
REQ-028a MEMWB: result=01, reg_write=1; next FETCH.
REQ-029 MEMWRITE: mem_req=mem_write=1, adr_src=1; hold until mem_ready, then FETCH.
REQ-030 EXEC_R: a=10, b=00; alu_op by funct7/funct3.
REQ-030a EXEC_R decode for funct7=0x00: f3 000 ADD, 110 OR, 111 AND, others ADD.
REQ-030b EXEC_R decode for other funct7: 0x01 MUL, 0x20 SUB, others ADD.
REQ-030c EXEC_R next state: ALUWB.
REQ-031 EXEC_I: a=10, b=01, imm 000; f3 000 ADD, 001 SLL, 010 SLT, 101 SRL, others ADD; next ALUWB.
REQ-032 ALUWB: result=00, reg_write=1; next FETCH.
REQ-033 BRANCH: a=10, b=00, SUB, result=00; pc_write=zero for f3 000, !zero for f3 001, 0 otherwise; next FETCH.
REQ-034 JALR_ADR: a=10, b=01, imm 000, ADD; next JAL.
REQ-034a JAL: a=01, b=10, ADD, result=00, pc_write=1; next ALUWB, which writes oldPC+4 to rd.
REQ-035 TRAP: illegal=1; all strobes 0; remain until reset.
REQ-036 mem_req SHALL stay high and address/controls stay stable for the whole wait; zero-wait (mem_ready already 1) completes in one cycle.
REQ-037 Non-memory instruction cycle counts: R/I 4, branch 3, JAL 4, JALR 5, AUIPC 3.
REQ-037a Memory instruction cycle counts: load 5, store 4; each memory wait cycle adds one.

Reset
REQ-038 Reset asserted SHALL force state FETCH and clear illegal, at any point including mid-access.
REQ-039 While reset is low, mem_req, mem_write, pc_write, ir_write and reg_write SHALL be 0.
REQ-039a First FETCH request occurs in the first cycle after reset deassertion.

Structure
REQ-040 State codes, opcode constants, alu_op/imm_src/result_src/alu_src codes SHALL live in shared package riscv_mc_pkg.
REQ-041 ALU-op decode SHALL be sub-module riscv_alu_dec (opcode, funct3, funct7, state class -> alu_op); the FSM stays in riscv_mc_sequencer.

Verification
REQ-042 add (0x33, f7 0, f3 0), mem_ready=1 -> states 0,1,6,8,0; reg_write only in ALUWB; alu_op 0010 in EXEC_R.
REQ-043 lw with mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles with mem_req=1, adr_src=1; MEMWB reg_write=1, result 01.
REQ-044 beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; f3 100 -> pc_write=0.
REQ-045 jalr -> states 1,11,10,8; pc_write=1 in JAL only; reg_write=1 in ALUWB.
REQ-046 opcode 0x7F -> TRAP, illegal=1 held; reset low -> FETCH, illegal=0.
REQ-047 reset low during MEMWRITE wait -> mem_req/mem_write drop immediately; after release, FETCH with mem_req=1.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared state, opcode and control-field codes for the multicycle sequencer
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // How the ALU decoder should pick alu_op for the current state
  typedef enum logic [1:0] {
    ALU_CLS_NONE  = 2'd0,
    ALU_CLS_ADD   = 2'd1,
    ALU_CLS_SUB   = 2'd2,
    ALU_CLS_FUNCT = 2'd3
  } alu_cls_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/riscv_alu_dec.sv
// rtl/riscv_alu_dec.sv - maps state class plus opcode/funct fields to the ALU operation
module riscv_alu_dec
  import riscv_mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  alu_cls_e   alu_cls_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_AND;
    unique case (alu_cls_i)
      ALU_CLS_ADD: alu_op_o = ALU_ADD;
      ALU_CLS_SUB: alu_op_o = ALU_SUB;
      ALU_CLS_FUNCT: begin
        alu_op_o = ALU_ADD;
        if (opcode_i == OP_R) begin
          if (funct7_i == 7'h00) begin
            case (funct3_i)
              3'b110:  alu_op_o = ALU_OR;
              3'b111:  alu_op_o = ALU_AND;
              default: alu_op_o = ALU_ADD;
            endcase
          end else begin
            case (funct7_i)
              7'h01:   alu_op_o = ALU_MUL;
              7'h20:   alu_op_o = ALU_SUB;
              default: alu_op_o = ALU_ADD;
            endcase
          end
        end else if (opcode_i == OP_I) begin
          case (funct3_i)
            3'b001:  alu_op_o = ALU_SLL;
            3'b010:  alu_op_o = ALU_SLT;
            3'b101:  alu_op_o = ALU_SRL;
            default: alu_op_o = ALU_ADD;
          endcase
        end
      end
      default: alu_op_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/riscv_mc_sequencer.sv
// rtl/riscv_mc_sequencer.sv - Moore control FSM for a multicycle RV32 datapath
module riscv_mc_sequencer
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_e   state_q, state_d;
  logic     illegal_q;
  alu_cls_e alu_cls;
  logic     mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  riscv_alu_dec u_alu_dec (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_cls_i (alu_cls),
    .alu_op_o  (alu_op)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_cls     = ALU_CLS_NONE;
    imm_src     = IMM_I;
    result_src  = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_cls    = ALU_CLS_ADD;
        result_src = RES_ALU;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute oldPC+imm: branch/jump target, or the AUIPC result
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_ADD;
        case (opcode)
          OP_BRANCH: imm_src = IMM_B;
          OP_JAL:    imm_src = IMM_J;
          OP_AUIPC:  imm_src = IMM_U;
          default:   imm_src = IMM_I;
        endcase
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_ADD;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEM;
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_cls   = ALU_CLS_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_cls    = ALU_CLS_SUB;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_write_s = zero;
          3'b001:  pc_write_s = !zero;
          default: pc_write_s = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JALR_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_ADD;
        state_d   = S_JAL;
      end
      S_JAL: begin
        // PC takes ALUOut (target); the ALU forms oldPC+4 for the link write
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_cls    = ALU_CLS_ADD;
        result_src = RES_ALUOUT;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_req   = mem_req_s & reset;
  assign mem_write = mem_write_s & reset;
  assign ir_write  = ir_write_s & reset;
  assign pc_write  = pc_write_s & reset;
  assign reg_write = reg_write_s & reset;
  assign illegal   = illegal_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// tb/tb_riscv_mc_sequencer.sv - scoreboard bench for the multicycle sequencer
module tb_riscv_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'h00;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_op, state_o;
  logic [2:0] imm_src;

  typedef struct {
    string       nm;
    logic [23:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  riscv_mc_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .result_src(result_src), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Monitor: one sample per cycle on the falling edge, compared against the oldest expectation
  always @(negedge clk) begin
    logic [23:0] act;
    exp_t        e;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, imm_src, result_src, illegal};
      n_vec++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got st=%0d ctl=%h expected st=%0d ctl=%h",
                 e.nm, act[23:20], act[19:0], e.v[23:20], e.v[19:0]);
      end
    end
  end

  task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic mr);
    @(posedge clk);
    #2;
    reset = r; opcode = op; funct3 = f3; funct7 = f7; zero = z; mem_ready = mr;
  endtask

  // Fields: state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, alu_op, imm, result, illegal
  task automatic ex(input string nm, input logic [3:0] st, input logic mq, input logic mw,
                    input logic ad, input logic ir, input logic pc, input logic rw,
                    input logic [1:0] a, input logic [1:0] b, input logic [3:0] op,
                    input logic [2:0] im, input logic [1:0] rs, input logic il);
    exp_t e;
    e.nm = nm;
    e.v  = {st, mq, mw, ad, ir, pc, rw, a, b, op, im, rs, il};
    q.push_back(e);
  endtask

  task automatic e_fetch(input string nm, input logic mr);
    ex(nm, 4'd0, 1, 0, 0, mr, mr, 0, 2'b00, 2'b10, 4'b0010, 3'b000, 2'b10, 0);
  endtask

  task automatic e_decode(input string nm, input logic [2:0] im);
    ex(nm, 4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'b0010, im, 2'b00, 0);
  endtask

  task automatic e_aluwb(input string nm);
    ex(nm, 4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);
  endtask

  task automatic e_inreset(input string nm);
    ex(nm, 4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0010, 3'b000, 2'b10, 0);
  endtask

  task automatic r_type(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [3:0] op);
    step(1, 7'h33, f3, f7, 0, 1); e_fetch({nm, "_fetch"}, 1);
    step(1, 7'h33, f3, f7, 0, 1); e_decode({nm, "_decode"}, 3'b000);
    step(1, 7'h33, f3, f7, 0, 1);
    ex({nm, "_exec_r"}, 4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, op, 3'b000, 2'b00, 0);
    step(1, 7'h33, f3, f7, 0, 1); e_aluwb({nm, "_aluwb"});
  endtask

  task automatic i_type(input string nm, input logic [2:0] f3, input logic [3:0] op);
    step(1, 7'h13, f3, 7'h00, 0, 1); e_fetch({nm, "_fetch"}, 1);
    step(1, 7'h13, f3, 7'h00, 0, 1); e_decode({nm, "_decode"}, 3'b000);
    step(1, 7'h13, f3, 7'h00, 0, 1);
    ex({nm, "_exec_i"}, 4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, op, 3'b000, 2'b00, 0);
    step(1, 7'h13, f3, 7'h00, 0, 1); e_aluwb({nm, "_aluwb"});
  endtask

  task automatic br(input string nm, input logic [2:0] f3, input logic z, input logic pc);
    step(1, 7'h63, f3, 7'h00, z, 1); e_fetch({nm, "_fetch"}, 1);
    step(1, 7'h63, f3, 7'h00, z, 1); e_decode({nm, "_decode"}, 3'b010);
    step(1, 7'h63, f3, 7'h00, z, 1);
    ex({nm, "_branch"}, 4'd9, 0, 0, 0, 0, pc, 0, 2'b10, 2'b00, 4'b0011, 3'b000, 2'b00, 0);
  endtask

  task automatic sw_head(input string nm);
    step(1, 7'h23, 3'b010, 7'h00, 0, 1); e_fetch({nm, "_fetch"}, 1);
    step(1, 7'h23, 3'b010, 7'h00, 0, 1); e_decode({nm, "_decode"}, 3'b000);
    step(1, 7'h23, 3'b010, 7'h00, 0, 1);
    ex({nm, "_memadr"}, 4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b0010, 3'b001, 2'b00, 0);
  endtask

  task automatic e_memwrite(input string nm);
    ex(nm, 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);
  endtask

  initial begin
    step(0, 7'h33, 3'b000, 7'h00, 0, 1); e_inreset("rst_hold0");
    step(0, 7'h33, 3'b000, 7'h00, 0, 1); e_inreset("rst_hold1");

    r_type("add", 3'b000, 7'h00, 4'b0010);
    r_type("sub", 3'b000, 7'h20, 4'b0011);
    r_type("mul", 3'b000, 7'h01, 4'b0111);
    r_type("or",  3'b110, 7'h00, 4'b0001);
    r_type("and", 3'b111, 7'h00, 4'b0000);
    i_type("slli", 3'b001, 4'b0100);
    i_type("slti", 3'b010, 4'b0110);
    i_type("srli", 3'b101, 4'b0101);

    // lw with two wait cycles in MEMREAD
    step(1, 7'h03, 3'b010, 7'h00, 0, 1); e_fetch("lw_fetch", 1);
    step(1, 7'h03, 3'b010, 7'h00, 0, 1); e_decode("lw_decode", 3'b000);
    step(1, 7'h03, 3'b010, 7'h00, 0, 1);
    ex("lw_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b0010, 3'b000, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 7'h03, 3'b010, 7'h00, 0, (i == 2));
      ex("lw_memread", 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 0);
    end
    step(1, 7'h03, 3'b010, 7'h00, 0, 1);
    ex("lw_memwb", 4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b01, 0);

    br("beq_z1", 3'b000, 1, 1);
    br("beq_z0", 3'b000, 0, 0);
    br("bne_z1", 3'b001, 1, 0);
    br("bne_z0", 3'b001, 0, 1);
    br("b100",   3'b100, 1, 0);

    step(1, 7'h67, 3'b000, 7'h00, 0, 1); e_fetch("jalr_fetch", 1);
    step(1, 7'h67, 3'b000, 7'h00, 0, 1); e_decode("jalr_decode", 3'b000);
    step(1, 7'h67, 3'b000, 7'h00, 0, 1);
    ex("jalr_adr", 4'd11, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b0010, 3'b000, 2'b00, 0);
    step(1, 7'h67, 3'b000, 7'h00, 0, 1);
    ex("jalr_jal", 4'd10, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 4'b0010, 3'b000, 2'b00, 0);
    step(1, 7'h67, 3'b000, 7'h00, 0, 1); e_aluwb("jalr_aluwb");

    step(1, 7'h6F, 3'b000, 7'h00, 0, 1); e_fetch("jal_fetch", 1);
    step(1, 7'h6F, 3'b000, 7'h00, 0, 1); e_decode("jal_decode", 3'b011);
    step(1, 7'h6F, 3'b000, 7'h00, 0, 1);
    ex("jal_jal", 4'd10, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 4'b0010, 3'b000, 2'b00, 0);
    step(1, 7'h6F, 3'b000, 7'h00, 0, 1); e_aluwb("jal_aluwb");

    sw_head("sw");
    step(1, 7'h23, 3'b010, 7'h00, 0, 0); e_memwrite("sw_wait");
    step(1, 7'h23, 3'b010, 7'h00, 0, 1); e_memwrite("sw_done");

    // Reset pulled mid-wait in MEMWRITE, then a waited FETCH before AUIPC
    sw_head("swr");
    step(1, 7'h23, 3'b010, 7'h00, 0, 0); e_memwrite("swr_wait");
    step(0, 7'h23, 3'b010, 7'h00, 0, 0); e_inreset("swr_reset");
    step(1, 7'h17, 3'b000, 7'h00, 0, 0); e_fetch("swr_fetch_wait", 0);
    step(1, 7'h17, 3'b000, 7'h00, 0, 1); e_fetch("auipc_fetch", 1);
    step(1, 7'h17, 3'b000, 7'h00, 0, 1); e_decode("auipc_decode", 3'b100);
    step(1, 7'h17, 3'b000, 7'h00, 0, 1); e_aluwb("auipc_aluwb");

    step(1, 7'h7F, 3'b000, 7'h00, 0, 1); e_fetch("trap_fetch", 1);
    step(1, 7'h7F, 3'b000, 7'h00, 0, 1); e_decode("trap_decode", 3'b000);
    for (int i = 0; i < 3; i++) begin
      step(1, 7'h33, 3'b000, 7'h00, 1, 1);
      ex("trap_hold", 4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 1);
    end
    step(0, 7'h33, 3'b000, 7'h00, 0, 1); e_inreset("trap_reset");
    step(1, 7'h33, 3'b000, 7'h00, 0, 1); e_fetch("post_trap_fetch", 1);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
